inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 88 ++++++++
 tb/tb_inst_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit with single outstanding request and 2-entry fetch buffer
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   out_pc;
    logic          outstanding;
    logic          discard;
    logic [CW-1:0] count;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];

    logic          rsp;
    logic          pop;
    logic          push;
    logic          grant;
    logic [OW-1:0] occ;
    logic [IW-1:0] wr_idx;

    // A response only counts when we are actually waiting for one; strays after reset are ignored.
    assign rsp      = imem_rvalid & outstanding;
    assign if_valid = rst_n & (count != '0);
    assign pop      = if_valid & ~stall;
    assign occ      = {1'b0, count} + OW'(outstanding) - OW'(pop);
    assign imem_req = rst_n & ~redirect & (~outstanding | rsp) & (occ < OW'(DEPTH));
    assign imem_addr = {fetch_pc[31:2], 2'b00};
    assign grant    = imem_req & imem_gnt;
    assign push     = rsp & ~discard & ~redirect;
    assign wr_idx   = IW'(count - CW'(pop));

    assign if_pc   = if_valid ? fifo_pc[0]   : 32'h0;
    assign if_inst = if_valid ? fifo_inst[0] : NOP;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (redirect) begin
            count       <= '0;
            fetch_pc    <= redirect_pc & ~32'h3;
            // An in-flight request that has not returned yet must be thrown away when it does.
            outstanding <= outstanding & ~imem_rvalid;
            discard     <= outstanding & ~imem_rvalid;
        end else begin
            if (grant) begin
                out_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= grant | (outstanding & ~rsp);
            if (rsp && discard) begin
                discard <= 1'b0;
            end
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    fifo_pc[i]   <= fifo_pc[i + 1];
                    fifo_inst[i] <= fifo_inst[i + 1];
                end
            end
            if (push) begin
                fifo_pc[wr_idx]   <= out_pc;
                fifo_inst[wr_idx] <= imem_rdata;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect, stall;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_pc, w_inst;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(w_valid), .if_pc(w_pc), .if_inst(w_inst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory answers one cycle after a grant with data equal to the address.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        g = imem_req & imem_gnt;
        a = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = g;
        imem_rdata  = a;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        @(negedge clk);
        tick();
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        chk("rst_valid", {31'h0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h13);
        tick();

        rst_n = 1'b1;
        #1;
        chk("c0_req", {31'h0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_wrap_addr", w_addr, 32'hFFFF_FFF8);
        chk("c0_valid", {31'h0, if_valid}, 32'd0);
        tick();
        #1;
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_wrap_addr", w_addr, 32'hFFFF_FFFC);
        chk("c1_valid", {31'h0, if_valid}, 32'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k == 0) chk("c2_wrap_addr", w_addr, 32'h0);
            chk("str_valid", {31'h0, if_valid}, 32'd1);
            chk("str_pc", if_pc, 32'(4 * k));
            chk("str_inst", if_inst, 32'(4 * k));
            chk("str_addr", imem_addr, 32'(4 * (k + 2)));
            tick();
        end

        stall = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("stall_req", {31'h0, imem_req}, 32'd0);
            chk("stall_valid", {31'h0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, 32'd24);
            tick();
        end
        stall = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("resume_pc", if_pc, 32'(24 + 4 * j));
            chk("resume_inst", if_inst, 32'(24 + 4 * j));
            chk("resume_addr", imem_addr, 32'(32 + 4 * j));
            chk("resume_req", {31'h0, imem_req}, 32'd1);
            tick();
        end

        imem_gnt = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("nognt_addr", imem_addr, 32'd48);
            chk("nognt_req", {31'h0, imem_req}, 32'd1);
            if (j == 0) chk("nognt_pc0", if_pc, 32'd40);
            if (j == 1) chk("nognt_pc1", if_pc, 32'd44);
            if (j == 2) begin
                chk("nognt_valid", {31'h0, if_valid}, 32'd0);
                chk("nognt_nop", if_inst, 32'h13);
            end
            tick();
        end
        imem_gnt = 1'b1;
        #1;
        chk("gnt_addr", imem_addr, 32'd48);
        tick();
        #1;
        chk("gnt_valid", {31'h0, if_valid}, 32'd0);
        chk("gnt_addr2", imem_addr, 32'd52);
        tick();
        #1;
        chk("gnt_pc", if_pc, 32'd48);
        chk("gnt_addr3", imem_addr, 32'd56);
        tick();

        // Hold back the response to addr 56 so the redirect sees it still outstanding.
        imem_rvalid = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        chk("redir_req", {31'h0, imem_req}, 32'd0);
        chk("redir_pop_pc", if_pc, 32'd52);
        tick();
        redirect = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'd56;
        #1;
        chk("redir_valid0", {31'h0, if_valid}, 32'd0);
        chk("redir_req1", {31'h0, imem_req}, 32'd1);
        chk("redir_addr", imem_addr, 32'h100);
        tick();
        #1;
        chk("discard_valid", {31'h0, if_valid}, 32'd0);
        chk("redir_addr2", imem_addr, 32'h104);
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        chk("redir_first_pc", if_pc, 32'h100);
        chk("redir_first_inst", if_inst, 32'h100);
        chk("redir2_req", {31'h0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("redir2_valid", {31'h0, if_valid}, 32'd0);
        chk("redir2_addr", imem_addr, 32'h200);
        chk("redir2_req1", {31'h0, imem_req}, 32'd1);
        tick();
        #1;
        chk("redir2_valid1", {31'h0, if_valid}, 32'd0);
        chk("redir2_addr2", imem_addr, 32'h204);
        tick();
        stall = 1'b1;
        #1;
        chk("redir2_pc", if_pc, 32'h200);
        chk("full_req", {31'h0, imem_req}, 32'd0);
        tick();

        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'h0, if_valid}, 32'd0);
        chk("mrst_inst", if_inst, 32'h13);
        chk("mrst_pc", if_pc, 32'h0);
        chk("mrst_req", {31'h0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b1; stall = 1'b0;
        #1;
        chk("post_valid", {31'h0, if_valid}, 32'd0);
        chk("post_addr", imem_addr, 32'h0);
        chk("post_req", {31'h0, imem_req}, 32'd1);
        tick();
        #1;
        chk("stray_valid", {31'h0, if_valid}, 32'd0);
        chk("post_addr2", imem_addr, 32'h4);
        tick();
        #1;
        chk("post_pc", if_pc, 32'h0);
        chk("post_inst", if_inst, 32'h0);
        chk("post_valid1", {31'h0, if_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
